// File: rtl/jt51_sh_pkg.sv
// Shared definitions for the per-slot ring sequencer: ring geometry,
// clear-sweep state encoding and a small slot arithmetic helper.
package jt51_sh_pkg;

   localparam int SLOTS  = 32;
   localparam int SLOT_W = 5;

   // Last slot of a lap; clear sweeps start and end on this boundary
   localparam logic [SLOT_W-1:0] LAST_SLOT = 5'd31;

   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_WAIT = 2'd1,
      CLR_RUN  = 2'd2
   } clr_state_t;

   // Next slot around the ring; the natural 5-bit wrap gives 31 -> 0
   function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
      return s + 1'b1;
   endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// Cen-gated slot counter naming the slot at the ring head, with the
// channel/operator split and a zero flag. Shared by every parameter ring.
module jt51_slot_cnt
   import jt51_sh_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   output logic [SLOT_W-1:0] slot,
   output logic [2:0]        ch,
   output logic [1:0]        op,
   output logic              zero
);

   // Advance one slot per enabled clock; the ring shifts on the same cen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
      end else if (cen) begin
         slot <= slot_inc(slot);
      end
   end

   assign ch   = slot[2:0];
   assign op   = slot[4:3];
   assign zero = (slot == '0);

endmodule

// File: rtl/jt51_sh_ctrl.sv
// Slot sequencer and write arbiter for one 32-stage shift-register ring.
// Holds a single pending CPU write until its slot reaches the ring head,
// runs whole-ring clear sweeps aligned to lap boundaries, and selects what
// is fed back into the ring each slot.
module jt51_sh_ctrl
   import jt51_sh_pkg::*;
#(
   parameter int               WIDTH  = 5,
   parameter logic [WIDTH-1:0] CLRVAL = '0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic [WIDTH-1:0]  ring_drop,
   output logic [WIDTH-1:0]  ring_din,
   output logic [SLOT_W-1:0] slot,
   output logic [2:0]        ch,
   output logic [1:0]        op,
   output logic              zero,
   input  logic              wr_req,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              wr_busy,
   output logic              wr_done,
   output logic              wr_err,
   input  logic              clr_req,
   output logic              clr_busy
);

   logic [SLOT_W-1:0] lat_slot;
   logic [WIDTH-1:0]  lat_data;
   logic              wr_hit;
   clr_state_t        clr_state;
   clr_state_t        clr_next;
   logic              lap_end;

   jt51_slot_cnt u_slot_cnt (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .slot (slot),
      .ch   (ch),
      .op   (op),
      .zero (zero)
   );

   // The pending write lands only on an enabled slot matching the latched
   // target; using registered wr_busy keeps wr_req out of the ring_din path
   assign wr_hit  = wr_busy && cen && (slot == lat_slot);
   assign lap_end = cen && (slot == LAST_SLOT);

   // Single-entry write latch with completion and rejection pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_busy  <= 1'b0;
         wr_done  <= 1'b0;
         wr_err   <= 1'b0;
         lat_slot <= '0;
         lat_data <= '0;
      end else begin
         wr_done <= wr_hit;
         wr_err  <= wr_req && wr_busy;
         if (wr_hit) begin
            wr_busy <= 1'b0;
         end
         if (wr_req && !wr_busy) begin
            wr_busy  <= 1'b1;
            lat_slot <= wr_slot;
            lat_data <= wr_data;
         end
      end
   end

   // Clear sweep state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_state <= CLR_IDLE;
      end else begin
         clr_state <= clr_next;
      end
   end

   // Clear sweep sequencing: wait for a lap boundary, then clear one full lap
   always_comb begin
      clr_next = clr_state;
      case (clr_state)
         CLR_IDLE: if (clr_req) clr_next = CLR_WAIT;
         CLR_WAIT: if (lap_end) clr_next = CLR_RUN;
         CLR_RUN:  if (lap_end) clr_next = CLR_IDLE;
         default:  clr_next = CLR_IDLE;
      endcase
   end

   assign clr_busy = (clr_state != CLR_IDLE);

   // Ring feedback select: a matching write beats the clear value, which
   // beats plain recirculation
   always_comb begin
      ring_din = ring_drop;
      if (wr_hit) begin
         ring_din = lat_data;
      end else if (clr_state == CLR_RUN) begin
         ring_din = CLRVAL;
      end
   end

endmodule

// File: tb/tb_jt51_sh_ctrl.sv
// Self-checking bench for jt51_sh_ctrl driving a 32-stage ring with cen on
// every second clock. A per-slot memory model predicts all outputs.
module tb_jt51_sh_ctrl;

   localparam int         WIDTH  = 5;
   localparam logic [4:0] CLRVAL = 5'h00;

   logic             clk = 1'b0;
   logic             rst;
   logic             cen;
   logic [WIDTH-1:0] ring_drop;
   logic [WIDTH-1:0] ring_din;
   logic [4:0]       slot;
   logic [2:0]       ch;
   logic [1:0]       op;
   logic             zero;
   logic             wr_req;
   logic [4:0]       wr_slot;
   logic [WIDTH-1:0] wr_data;
   logic             wr_busy;
   logic             wr_done;
   logic             wr_err;
   logic             clr_req;
   logic             clr_busy;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   bit cen_ph = 1'b0;

   logic [WIDTH-1:0] ring_q [32];

   // Model: contents of each slot, the pending write and the clear sweep
   int               m_slot;
   logic [WIDTH-1:0] m_mem [32];
   bit               m_pend;
   int               m_pslot;
   logic [WIDTH-1:0] m_pdata;
   bit               m_done;
   bit               m_err;
   bit               m_wait;
   int               m_left;

   jt51_sh_ctrl #(.WIDTH(WIDTH), .CLRVAL(CLRVAL)) dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .ring_drop (ring_drop),
      .ring_din  (ring_din),
      .slot      (slot),
      .ch        (ch),
      .op        (op),
      .zero      (zero),
      .wr_req    (wr_req),
      .wr_slot   (wr_slot),
      .wr_data   (wr_data),
      .wr_busy   (wr_busy),
      .wr_done   (wr_done),
      .wr_err    (wr_err),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy)
   );

   always #5 clk = ~clk;

   // The ring under control: shifts on cen and resets with the controller
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) ring_q[i] <= '0;
      end else if (cen) begin
         ring_q[0] <= ring_din;
         for (int i = 1; i < 32; i++) ring_q[i] <= ring_q[i-1];
      end
   end
   assign ring_drop = ring_q[31];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at every clock edge, using the state before the edge
   always @(posedge clk or posedge rst) begin : model
      bit hit;
      bit pre_pend;
      bit pre_wait;
      int pre_left;
      if (rst) begin
         m_slot = 0;
         for (int i = 0; i < 32; i++) m_mem[i] = '0;
         m_pend = 0; m_pslot = 0; m_pdata = '0;
         m_done = 0; m_err = 0; m_wait = 0; m_left = 0;
      end else begin
         pre_pend = m_pend;
         pre_wait = m_wait;
         pre_left = m_left;
         hit = m_pend && cen && (m_slot == m_pslot);
         m_done = hit;
         m_err  = wr_req && pre_pend;
         if (cen) begin
            if (hit) m_mem[m_slot] = m_pdata;
            else if (pre_left > 0) m_mem[m_slot] = CLRVAL;
            if (pre_left > 0) m_left = m_left - 1;
            if (pre_wait && m_slot == 31) begin
               m_wait = 0;
               m_left = 32;
            end
            m_slot = (m_slot + 1) % 32;
         end
         if (hit) m_pend = 0;
         if (wr_req && !pre_pend) begin
            m_pend  = 1;
            m_pslot = int'(wr_slot);
            m_pdata = wr_data;
         end
         if (clr_req && !pre_wait && pre_left == 0) m_wait = 1;
      end
   end

   // Compare every output against the model away from the active edge
   always @(negedge clk) begin : compare
      logic [WIDTH-1:0] e_din;
      if (cen && m_pend && m_slot == m_pslot) e_din = m_pdata;
      else if (m_left > 0) e_din = CLRVAL;
      else e_din = m_mem[m_slot];
      check_output("slot", 32'(slot), 32'(m_slot));
      check_output("ch", 32'(ch), 32'(m_slot % 8));
      check_output("op", 32'(op), 32'(m_slot / 8));
      check_output("zero", 32'(zero), 32'(m_slot == 0));
      check_output("ring_drop", 32'(ring_drop), 32'(m_mem[m_slot]));
      check_output("ring_din", 32'(ring_din), 32'(e_din));
      check_output("wr_busy", 32'(wr_busy), 32'(m_pend));
      check_output("wr_done", 32'(wr_done), 32'(m_done));
      check_output("wr_err", 32'(wr_err), 32'(m_err));
      check_output("clr_busy", 32'(clr_busy), 32'(m_wait || m_left > 0));
      if (wr_done) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cen_ph  = !cen_ph;
      cen     = cen_ph;
      wr_req  = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic apply_stimulus(input bit do_wr, input logic [4:0] s, input logic [4:0] d, input bit do_clr);
      wr_req  = do_wr;
      wr_slot = s;
      wr_data = d;
      clr_req = do_clr;
   endtask

   task automatic wait_slot(input int target);
      for (int n = 0; n < 300; n++) begin
         if (int'(slot) == target && cen) return;
         step();
      end
      total++; bad++;
      $display("[TB] FAIL wait_slot: slot=%0d never reached %0d", slot, target);
   endtask

   task automatic wait_not_busy();
      for (int n = 0; n < 300; n++) begin
         if (!wr_busy) return;
         step();
      end
      total++; bad++;
      $display("[TB] FAIL wait_wr: wr_busy=%0b required 0", wr_busy);
   endtask

   task automatic wait_clr_idle();
      for (int n = 0; n < 300; n++) begin
         if (!clr_busy) return;
         step();
      end
      total++; bad++;
      $display("[TB] FAIL wait_clr: clr_busy=%0b required 0", clr_busy);
   endtask

   initial begin
      int base;
      bit seen;
      rst = 1'b1; cen = 1'b0;
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values and two full laps
      check_output("rst_slot", 32'(slot), 32'd0);
      check_output("rst_zero", 32'(zero), 32'd1);
      check_output("rst_busy", 32'(wr_busy), 32'd0);
      check_output("rst_clr", 32'(clr_busy), 32'd0);
      repeat (128) step();
      check_output("two_laps_slot", 32'(slot), 32'd0);

      // Single write to slot 5 issued at slot 2
      wait_slot(2);
      apply_stimulus(1'b1, 5'd5, 5'h1A, 1'b0);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         step();
         if (wr_done) seen = 1;
      end
      check_output("wr_done_seen", 32'(seen), 32'd1);
      check_output("wr_done_slot", 32'(slot), 32'd6);
      wait_slot(5);
      check_output("drop_s5", 32'(ring_drop), 32'h1A);
      wait_slot(6);
      check_output("drop_s6", 32'(ring_drop), 32'h00);

      // Write while busy is rejected
      wait_slot(10);
      apply_stimulus(1'b1, 5'd20, 5'h0C, 1'b0);
      step();
      apply_stimulus(1'b1, 5'd21, 5'h15, 1'b0);
      step();
      check_output("wr_err_pulse", 32'(wr_err), 32'd1);
      step();
      check_output("wr_err_clear", 32'(wr_err), 32'd0);
      wait_not_busy();
      wait_slot(20);
      check_output("drop_s20", 32'(ring_drop), 32'h0C);
      wait_slot(21);
      check_output("drop_s21", 32'(ring_drop), 32'h00);

      // Preload every slot, then clear sweep requested at slot 10
      for (int k = 0; k < 32; k++) begin
         wait_not_busy();
         apply_stimulus(1'b1, 5'(k), 5'h1F, 1'b0);
         step();
      end
      wait_not_busy();
      repeat (64) step();
      wait_slot(10);
      check_output("preload_s10", 32'(ring_drop), 32'h1F);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1);
      step();
      check_output("clr_busy_set", 32'(clr_busy), 32'd1);
      wait_clr_idle();
      check_output("clr_end_slot", 32'(slot), 32'd0);
      wait_slot(15);
      check_output("clr_s15", 32'(ring_drop), 32'(CLRVAL));

      // Write during the clear sweep survives it
      wait_slot(20);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1);
      step();
      wait_slot(1);
      check_output("run_busy", 32'(clr_busy), 32'd1);
      base = done_cnt;
      apply_stimulus(1'b1, 5'd7, 5'h03, 1'b0);
      step();
      wait_clr_idle();
      check_output("run_wr_done_once", 32'(done_cnt - base), 32'd1);
      wait_slot(7);
      check_output("run_s7", 32'(ring_drop), 32'h03);
      wait_slot(8);
      check_output("run_s8", 32'(ring_drop), 32'(CLRVAL));

      // Reset mid-sweep with a write pending
      wait_slot(20);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1);
      step();
      wait_slot(3);
      apply_stimulus(1'b1, 5'd25, 5'h09, 1'b0);
      step();
      wait_slot(10);
      #2 rst = 1'b1;
      #1;
      check_output("mid_rst_slot", 32'(slot), 32'd0);
      check_output("mid_rst_busy", 32'(wr_busy), 32'd0);
      check_output("mid_rst_clr", 32'(clr_busy), 32'd0);
      check_output("mid_rst_done", 32'(wr_done), 32'd0);
      base = done_cnt;
      @(posedge clk);
      #1 rst = 1'b0;
      check_output("post_rst_slot", 32'(slot), 32'd0);
      repeat (100) step();
      check_output("no_done_after_rst", 32'(done_cnt - base), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         step();
         apply_stimulus($urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), $urandom_range(0, 63) == 0);
      end
      step();
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
